imu_bias_cal: RTL and testbench

IMU_BIAS_CAL -- requirements
Module: imu_bias_cal

---
 rtl/imu_bias_cal.sv | 160 ++++++++++++++++
 tb/tb_imu_bias_cal.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imu_bias_cal.sv
// Gyro bias calibration (average 2^CAL_SHIFT samples) then bias-corrected gyro / accel passthrough.
// Latency: one cycle from in_valid to out_valid in RUN; no output while calibrating.
// Backpressure: none, one sample per cycle. Optional accel IIR low-pass under `define ACCEL_LPF_EN.
module imu_bias_cal #(
    parameter int CAL_SHIFT = 6,
    parameter int LPF_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic signed [15:0] in_accel_x,
    input  logic signed [15:0] in_accel_y,
    input  logic signed [15:0] in_accel_z,
    input  logic signed [15:0] in_gyro_x,
    input  logic signed [15:0] in_gyro_y,
    input  logic signed [15:0] in_gyro_z,
    input  logic               recal,
    output logic               out_valid,
    output logic signed [15:0] out_accel_x,
    output logic signed [15:0] out_accel_y,
    output logic signed [15:0] out_accel_z,
    output logic signed [15:0] out_gyro_x,
    output logic signed [15:0] out_gyro_y,
    output logic signed [15:0] out_gyro_z,
    output logic               cal_done
);

    localparam int AW = 16 + CAL_SHIFT;
    localparam int CW = CAL_SHIFT + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << CAL_SHIFT) - 1);

    if (CAL_SHIFT < 1 || LPF_SHIFT < 0 || LPF_SHIFT > 15) begin : g_param_chk
        $error("imu_bias_cal: shift parameter out of range");
    end

    typedef enum logic {CAL, RUN} state_t;

    state_t                state;
    logic signed [AW-1:0]  acc_x, acc_y, acc_z;
    logic signed [AW-1:0]  acc_x_nxt, acc_y_nxt, acc_z_nxt;
    logic        [CW-1:0]  cnt;
    logic signed [15:0]    bias_x, bias_y, bias_z;
    logic signed [15:0]    accel_x_src, accel_y_src, accel_z_src;
    logic                  accept;

    function automatic logic signed [15:0] sub_sat(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        logic signed [16:0] d;
        d = {a[15], a} - {b[15], b};
        if (d[16] != d[15])
            return d[16] ? 16'sh8000 : 16'sh7fff;
        return d[15:0];
    endfunction

    assign accept    = in_valid && !recal;
    assign acc_x_nxt = acc_x + {{CAL_SHIFT{in_gyro_x[15]}}, in_gyro_x};
    assign acc_y_nxt = acc_y + {{CAL_SHIFT{in_gyro_y[15]}}, in_gyro_y};
    assign acc_z_nxt = acc_z + {{CAL_SHIFT{in_gyro_z[15]}}, in_gyro_z};

`ifdef ACCEL_LPF_EN
    logic signed [15:0] lpf_x, lpf_y, lpf_z;
    logic               lpf_init;

    function automatic logic signed [15:0] lpf_step(input logic signed [15:0] l,
                                                    input logic signed [15:0] a);
        logic signed [16:0] d;
        logic signed [16:0] s;
        d = {a[15], a} - {l[15], l};
        s = {l[15], l} + (d >>> LPF_SHIFT);
        return 16'(s);
    endfunction

    // First accepted sample seeds the filter so it does not ramp up from zero.
    assign accel_x_src = lpf_init ? lpf_step(lpf_x, in_accel_x) : in_accel_x;
    assign accel_y_src = lpf_init ? lpf_step(lpf_y, in_accel_y) : in_accel_y;
    assign accel_z_src = lpf_init ? lpf_step(lpf_z, in_accel_z) : in_accel_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lpf_x    <= '0;
            lpf_y    <= '0;
            lpf_z    <= '0;
            lpf_init <= 1'b0;
        end else if (accept) begin
            lpf_x    <= accel_x_src;
            lpf_y    <= accel_y_src;
            lpf_z    <= accel_z_src;
            lpf_init <= 1'b1;
        end
    end
`else
    assign accel_x_src = in_accel_x;
    assign accel_y_src = in_accel_y;
    assign accel_z_src = in_accel_z;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CAL;
            acc_x       <= '0;
            acc_y       <= '0;
            acc_z       <= '0;
            cnt         <= '0;
            bias_x      <= '0;
            bias_y      <= '0;
            bias_z      <= '0;
            cal_done    <= 1'b0;
            out_valid   <= 1'b0;
            out_accel_x <= '0;
            out_accel_y <= '0;
            out_accel_z <= '0;
            out_gyro_x  <= '0;
            out_gyro_y  <= '0;
            out_gyro_z  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (recal) begin
                state    <= CAL;
                acc_x    <= '0;
                acc_y    <= '0;
                acc_z    <= '0;
                cnt      <= '0;
                cal_done <= 1'b0;
            end else if (in_valid) begin
                case (state)
                    CAL: begin
                        if (cnt == LAST) begin
                            // Top 16 bits of the sum == floor(sum / 2^CAL_SHIFT).
                            bias_x   <= acc_x_nxt[CAL_SHIFT +: 16];
                            bias_y   <= acc_y_nxt[CAL_SHIFT +: 16];
                            bias_z   <= acc_z_nxt[CAL_SHIFT +: 16];
                            acc_x    <= '0;
                            acc_y    <= '0;
                            acc_z    <= '0;
                            cnt      <= '0;
                            cal_done <= 1'b1;
                            state    <= RUN;
                        end else begin
                            acc_x <= acc_x_nxt;
                            acc_y <= acc_y_nxt;
                            acc_z <= acc_z_nxt;
                            cnt   <= cnt + CW'(1);
                        end
                    end
                    RUN: begin
                        out_valid   <= 1'b1;
                        out_gyro_x  <= sub_sat(in_gyro_x, bias_x);
                        out_gyro_y  <= sub_sat(in_gyro_y, bias_y);
                        out_gyro_z  <= sub_sat(in_gyro_z, bias_z);
                        out_accel_x <= accel_x_src;
                        out_accel_y <= accel_y_src;
                        out_accel_z <= accel_z_src;
                    end
                    default: state <= CAL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imu_bias_cal.sv
// Directed bench for imu_bias_cal: calibration, correction, saturation, recal and async reset.
module tb_imu_bias_cal;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_accel_x = '0, in_accel_y = '0, in_accel_z = '0;
    logic signed [15:0] in_gyro_x = '0, in_gyro_y = '0, in_gyro_z = '0;
    logic               recal = 1'b0;
    logic               out_valid;
    logic signed [15:0] out_accel_x, out_accel_y, out_accel_z;
    logic signed [15:0] out_gyro_x, out_gyro_y, out_gyro_z;
    logic               cal_done;

    int n_assert = 0;
    int n_fail   = 0;
    int ov_cnt   = 0;
    int ov0      = 0;

    imu_bias_cal dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_accel_x  (in_accel_x),
        .in_accel_y  (in_accel_y),
        .in_accel_z  (in_accel_z),
        .in_gyro_x   (in_gyro_x),
        .in_gyro_y   (in_gyro_y),
        .in_gyro_z   (in_gyro_z),
        .recal       (recal),
        .out_valid   (out_valid),
        .out_accel_x (out_accel_x),
        .out_accel_y (out_accel_y),
        .out_accel_z (out_accel_z),
        .out_gyro_x  (out_gyro_x),
        .out_gyro_y  (out_gyro_y),
        .out_gyro_z  (out_gyro_z),
        .cal_done    (cal_done)
    );

    always #5 clk = ~clk;

    // Count output pulses shortly after each edge, well clear of the negedge checks.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) ov_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic drive(input logic signed [15:0] gx, input logic signed [15:0] gy,
                         input logic signed [15:0] gz, input logic signed [15:0] ax,
                         input logic rc);
        @(negedge clk);
        in_gyro_x  = gx;
        in_gyro_y  = gy;
        in_gyro_z  = gz;
        in_accel_x = ax;
        in_accel_y = -ax;
        in_accel_z = 16'sd0;
        in_valid   = 1'b1;
        recal      = rc;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        recal    = 1'b0;
    endtask

    task automatic recal_pulse();
        @(negedge clk);
        in_valid = 1'b0;
        recal    = 1'b1;
    endtask

    task automatic cal(input int n, input logic signed [15:0] gx_even,
                       input logic signed [15:0] gx_odd, input logic signed [15:0] gy);
        for (int i = 0; i < n; i++)
            drive((i % 2) ? gx_odd : gx_even, gy, 16'sd0, 16'sd0, 1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
        chk("rst_cal_done",  {15'b0, cal_done},  16'd0);
        chk("rst_gyro_x",    out_gyro_x,         16'd0);
        chk("rst_accel_x",   out_accel_x,        16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic calibration: bias (100, -50, 0)
        ov0 = ov_cnt;
        cal(63, 16'sd100, 16'sd100, -16'sd50);
        idle();
        chk("cal63_not_done", {15'b0, cal_done}, 16'd0);
        cal(1, 16'sd100, 16'sd100, -16'sd50);
        idle();
        chk("cal64_done", {15'b0, cal_done}, 16'd1);
        chk("cal_no_out", 16'(ov_cnt - ov0), 16'd0);
        drive(16'sd110, 16'sd0, 16'sd0, 16'sd1234, 1'b0);
        idle();
        chk("run_out_valid", {15'b0, out_valid}, 16'd1);
        chk("run_gyro_x", out_gyro_x, 16'd10);
        chk("run_gyro_y", out_gyro_y, 16'd50);
        chk("run_gyro_z", out_gyro_z, 16'd0);
`ifdef ACCEL_LPF_EN
        chk("run_accel_x", out_accel_x, 16'd308);
`else
        chk("run_accel_x", out_accel_x, 16'd1234);
        chk("run_accel_y", out_accel_y, 16'(-1234));
`endif
        idle();
        chk("hold_valid_low", {15'b0, out_valid}, 16'd0);
        chk("hold_gyro_x", out_gyro_x, 16'd10);

        // Saturation
        drive(-16'sd32768, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        idle();
        chk("sat_neg_x", out_gyro_x, 16'h8000);
        drive(16'sd32767, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        idle();
        chk("nosat_x", out_gyro_x, 16'd32667);
        recal_pulse();
        idle();
        chk("recal_clears_done", {15'b0, cal_done}, 16'd0);
        cal(64, -16'sd100, -16'sd100, 16'sd100);
        idle();
        chk("recal2_done", {15'b0, cal_done}, 16'd1);
        drive(16'sd32767, -16'sd32768, 16'sd0, 16'sd0, 1'b0);
        idle();
        chk("sat_pos_x", out_gyro_x, 16'h7fff);
        chk("sat_neg_y", out_gyro_y, 16'h8000);

        // Alternating 3 / -4 -> bias -1 by floor division
        recal_pulse();
        cal(64, 16'sd3, -16'sd4, 16'sd0);
        idle();
        drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        idle();
        chk("floor_bias_x", out_gyro_x, 16'd1);

        // recal coincident with in_valid in RUN
        ov0 = ov_cnt;
        drive(16'sd5, 16'sd0, 16'sd0, 16'sd0, 1'b1);
        idle();
        chk("recal_vld_no_out", 16'(ov_cnt - ov0), 16'd0);
        chk("recal_vld_done_low", {15'b0, cal_done}, 16'd0);
        cal(63, 16'sd7, 16'sd7, 16'sd0);
        idle();
        chk("recal_63_not_done", {15'b0, cal_done}, 16'd0);
        chk("recal_63_no_out", 16'(ov_cnt - ov0), 16'd0);
        cal(1, 16'sd7, 16'sd7, 16'sd0);
        idle();
        chk("recal_64_done", {15'b0, cal_done}, 16'd1);
        drive(16'sd17, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        idle();
        chk("recal_resume_x", out_gyro_x, 16'd10);
        chk("recal_resume_cnt", 16'(ov_cnt - ov0), 16'd1);

        // Accel step 0 -> 400
        drive(16'sd17, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        drive(16'sd17, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        idle();
        chk("accel_warm", out_accel_x, 16'd0);
        drive(16'sd17, 16'sd0, 16'sd0, 16'sd400, 1'b0);
        idle();
`ifdef ACCEL_LPF_EN
        chk("accel_step1", out_accel_x, 16'd100);
`else
        chk("accel_step1", out_accel_x, 16'd400);
`endif
        drive(16'sd17, 16'sd0, 16'sd0, 16'sd400, 1'b0);
        idle();
`ifdef ACCEL_LPF_EN
        chk("accel_step2", out_accel_x, 16'd175);
`else
        chk("accel_step2", out_accel_x, 16'd400);
`endif
        drive(16'sd17, 16'sd0, 16'sd0, 16'sd400, 1'b0);
        idle();
`ifdef ACCEL_LPF_EN
        chk("accel_step3", out_accel_x, 16'd231);
`else
        chk("accel_step3", out_accel_x, 16'd400);
`endif

        // Async reset after 30 calibration samples
        recal_pulse();
        cal(30, 16'sd500, 16'sd500, 16'sd0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gyro_x",  out_gyro_x,  16'd0);
        chk("arst_accel_x", out_accel_x, 16'd0);
        chk("arst_valid",   {15'b0, out_valid}, 16'd0);
        chk("arst_done",    {15'b0, cal_done},  16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cal(63, 16'sd200, 16'sd200, 16'sd0);
        idle();
        chk("arst_63_not_done", {15'b0, cal_done}, 16'd0);
        cal(1, 16'sd200, 16'sd200, 16'sd0);
        idle();
        chk("arst_64_done", {15'b0, cal_done}, 16'd1);
        drive(16'sd200, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        idle();
        chk("arst_bias_zero", out_gyro_x, 16'd0);
        drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        idle();
        chk("arst_bias_neg", out_gyro_x, 16'(-200));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
